// File: rtl/cpu_isa_pkg.sv
// cpu_isa_pkg: opcode map, error codes and state encodings shared by the
// control decoder and the program loader.
`default_nettype none

package cpu_isa_pkg;

  localparam logic [3:0] OP_RTYPE = 4'b0000;
  localparam logic [3:0] OP_ADDI  = 4'b0001;
  localparam logic [3:0] OP_AND   = 4'b0010;
  localparam logic [3:0] OP_ANDI  = 4'b0011;
  localparam logic [3:0] OP_ORI   = 4'b0100;
  localparam logic [3:0] OP_JMP   = 4'b0101;
  localparam logic [3:0] OP_BEQ   = 4'b0110;
  localparam logic [3:0] OP_LUI   = 4'b0111;
  localparam logic [3:0] OP_OR    = 4'b1000;
  localparam logic [3:0] OP_XOR   = 4'b1001;
  localparam logic [3:0] OP_LW    = 4'b1010;
  localparam logic [3:0] OP_SLL   = 4'b1011;
  localparam logic [3:0] OP_SRL   = 4'b1100;
  localparam logic [3:0] OP_SW    = 4'b1101;

  localparam int OP_LSB = 12;
  localparam int RS_LSB = 8;
  localparam int RT_LSB = 4;

  localparam logic [1:0] ERR_NONE       = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL_OP = 2'b01;
  localparam logic [1:0] ERR_IMM_RANGE  = 2'b10;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCEPT = 2'd1;
  localparam logic [1:0] ST_WRITE  = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  typedef enum logic [2:0] {
    FMT_R, FMT_I, FMT_SHIFT, FMT_LUI, FMT_JMP, FMT_BAD
  } fmt_e;

  function automatic fmt_e op_format(input logic [3:0] op);
    case (op)
      OP_RTYPE, OP_AND, OP_OR, OP_XOR:                 return FMT_R;
      OP_ADDI, OP_ANDI, OP_ORI, OP_BEQ, OP_LW, OP_SW:  return FMT_I;
      OP_SLL, OP_SRL:                                  return FMT_SHIFT;
      OP_LUI:                                          return FMT_LUI;
      OP_JMP:                                          return FMT_JMP;
      default:                                         return FMT_BAD;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/isa_field_pack.sv
// isa_field_pack: packs opcode and fields into a 16-bit word and checks
// that the opcode exists and the immediate fits its format.
`default_nettype none

module isa_field_pack
  import cpu_isa_pkg::*;
(
  input  logic [3:0]  op_i,
  input  logic [3:0]  rs_i,
  input  logic [3:0]  rt_i,
  input  logic [3:0]  rd_i,
  input  logic [11:0] imm_i,
  output logic [15:0] word_o,
  output logic        legal_o,
  output logic [1:0]  err_code_o
);

  logic w_in_range;

  always_comb begin
    word_o     = '0;
    w_in_range = 1'b0;
    legal_o    = 1'b0;
    err_code_o = ERR_ILLEGAL_OP;
    case (op_format(op_i))
      FMT_R: begin
        word_o     = {op_i, rs_i, rt_i, rd_i};
        w_in_range = 1'b1;
      end
      FMT_I: begin
        word_o     = {op_i, rs_i, rt_i, imm_i[3:0]};
        // signed -8..7: the upper bits must all replicate bit 3
        w_in_range = (imm_i[11:3] == '0) || (imm_i[11:3] == '1);
      end
      FMT_SHIFT: begin
        word_o     = {op_i, rs_i, rt_i, imm_i[3:0]};
        w_in_range = (imm_i[11:4] == '0);
      end
      FMT_LUI: begin
        word_o     = {op_i, rt_i, imm_i[7:0]};
        w_in_range = (imm_i[11:8] == '0);
      end
      FMT_JMP: begin
        word_o     = {op_i, imm_i};
        w_in_range = 1'b1;
      end
      default: ;
    endcase
    if (op_format(op_i) != FMT_BAD) begin
      legal_o    = w_in_range;
      err_code_o = w_in_range ? ERR_NONE : ERR_IMM_RANGE;
    end
  end

endmodule

`default_nettype wire

// File: rtl/instr_encoder.sv
// instr_encoder: accepts field-level instruction requests, encodes them and
// writes them sequentially into instruction memory, one word per two cycles.
`default_nettype none

module instr_encoder
  import cpu_isa_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_op,
  input  logic [3:0]        req_rs,
  input  logic [3:0]        req_rt,
  input  logic [3:0]        req_rd,
  input  logic [11:0]       req_imm,
  input  logic              req_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic              err,
  output logic [1:0]        err_code
);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              err_q, err_d;
  logic [1:0]        err_code_q, err_code_d;
  logic              full_q, full_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic              last_q, last_d;

  logic [15:0]       w_word;
  logic              w_legal;
  logic [1:0]        w_err_code;

  isa_field_pack u_pack (
    .op_i       (req_op),
    .rs_i       (req_rs),
    .rt_i       (req_rt),
    .rd_i       (req_rd),
    .imm_i      (req_imm),
    .word_o     (w_word),
    .legal_o    (w_legal),
    .err_code_o (w_err_code)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      count_q    <= '0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
      full_q     <= 1'b0;
      word_q     <= '0;
      last_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      count_q    <= count_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
      full_q     <= full_d;
      word_q     <= word_d;
      last_q     <= last_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    count_d    = count_q;
    err_d      = err_q;
    err_code_d = err_code_q;
    full_d     = full_q;
    word_d     = word_q;
    last_d     = last_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          ptr_d      = '0;
          count_d    = '0;
          err_d      = 1'b0;
          err_code_d = ERR_NONE;
          full_d     = 1'b0;
          state_d    = ST_ACCEPT;
        end
      end
      ST_ACCEPT: begin
        if (req_valid) begin
          if (w_legal) begin
            word_d  = DATA_W'(w_word);
            last_d  = req_last;
            state_d = ST_WRITE;
          end else begin
            err_d = 1'b1;
            if (err_code_q == ERR_NONE) err_code_d = w_err_code;
            if (req_last) state_d = ST_DONE;
          end
        end
      end
      default: begin
        ptr_d   = ptr_q + 1'b1;
        count_d = count_q + 1'b1;
        full_d  = (ptr_q == '1);
        state_d = (last_q || ptr_q == '1) ? ST_DONE : ST_ACCEPT;
      end
    endcase
  end

  always_comb begin
    req_ready = (state_q == ST_ACCEPT);
    imem_we   = (state_q == ST_WRITE);
    busy      = (state_q == ST_ACCEPT) || (state_q == ST_WRITE);
    done      = (state_q == ST_DONE);
  end

  assign imem_addr  = ptr_q;
  assign imem_wdata = word_q;
  assign full       = full_q;
  assign count      = count_q;
  assign err        = err_q;
  assign err_code   = err_code_q;

endmodule

`default_nettype wire

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed vectors against two encoders sharing one request
// bus, the second sized to four words so the memory-full path is reachable.
`default_nettype none

module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        req_valid = 1'b0;
  logic [3:0]  req_op = '0, req_rs = '0, req_rt = '0, req_rd = '0;
  logic [11:0] req_imm = '0;
  logic        req_last = 1'b0;

  logic        req_ready, imem_we, busy, done, full, err;
  logic [3:0]  imem_addr;
  logic [15:0] imem_wdata;
  logic [4:0]  count;
  logic [1:0]  err_code;

  logic        req_ready2, imem_we2, busy2, done2, full2, err2;
  logic [1:0]  imem_addr2;
  logic [15:0] imem_wdata2;
  logic [2:0]  count2;
  logic [1:0]  err_code2;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  instr_encoder #(.ADDR_W(4), .DATA_W(16)) u_dut (
    .clk(clk), .rst(rst), .start(start), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd), .req_imm(req_imm),
    .req_last(req_last), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .busy(busy), .done(done), .full(full), .count(count), .err(err), .err_code(err_code)
  );

  instr_encoder #(.ADDR_W(2), .DATA_W(16)) u_dut_small (
    .clk(clk), .rst(rst), .start(start), .req_valid(req_valid), .req_ready(req_ready2),
    .req_op(req_op), .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd), .req_imm(req_imm),
    .req_last(req_last), .imem_we(imem_we2), .imem_addr(imem_addr2), .imem_wdata(imem_wdata2),
    .busy(busy2), .done(done2), .full(full2), .count(count2), .err(err2), .err_code(err_code2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  // Returns on the negedge of the cycle after the accepting edge.
  task automatic send(input string tag, input logic [3:0] op, rs, rt, rd,
                      input logic [11:0] imm, input logic last,
                      input logic exp_we, input logic [3:0] exp_addr,
                      input logic [15:0] exp_word);
    int n;
    @(negedge clk);
    req_op = op; req_rs = rs; req_rt = rt; req_rd = rd;
    req_imm = imm; req_last = last; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      chk({tag, "_handshake_timeout"}, 0, 1);
      req_valid = 1'b0;
      return;
    end
    @(negedge clk);
    req_valid = 1'b0;
    req_last  = 1'b0;
    chk({tag, "_we"}, 32'(imem_we), 32'(exp_we));
    if (exp_we) begin
      chk({tag, "_addr"}, 32'(imem_addr), 32'(exp_addr));
      chk({tag, "_wdata"}, 32'(imem_wdata), 32'(exp_word));
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_status"},
        32'({req_ready, imem_we, busy, done, full, err, err_code, imem_addr, count}), 0);
    chk({tag, "_wdata"}, 32'(imem_wdata), 0);
    chk({tag, "_status_small"},
        32'({req_ready2, imem_we2, busy2, done2, full2, err2, err_code2, imem_addr2, count2}), 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;

    // addi rs=2 rt=1 imm=5, last
    do_start();
    chk("start_busy", 32'({busy, req_ready}), 32'b11);
    send("addi", 4'h1, 4'd2, 4'd1, 4'd0, 12'd5, 1'b1, 1'b1, 4'd0, 16'h1215);
    @(negedge clk);
    chk("t1_done_count", 32'({done, busy, count}), {25'd0, 1'b1, 1'b0, 5'd1});

    // R-type then jmp
    do_start();
    send("rtype", 4'h0, 4'd3, 4'd4, 4'd5, 12'd0, 1'b0, 1'b1, 4'd0, 16'h0345);
    send("jmp", 4'h5, 4'd0, 4'd0, 4'd0, 12'hABC, 1'b1, 1'b1, 4'd1, 16'h5ABC);
    @(negedge clk);
    chk("t2_done_count", 32'({done, count}), {26'd0, 1'b1, 5'd2});

    // signed immediate boundaries
    do_start();
    send("addi_m8", 4'h1, 4'd1, 4'd2, 4'd0, 12'hFF8, 1'b0, 1'b1, 4'd0, 16'h1128);
    send("addi_p8", 4'h1, 4'd1, 4'd2, 4'd0, 12'h008, 1'b0, 1'b0, 4'd0, 16'h0);
    chk("t3_err", 32'({err, err_code, count}), {24'd0, 1'b1, 2'b10, 5'd1});
    send("bad_last", 4'hE, 4'd0, 4'd0, 4'd0, 12'd0, 1'b1, 1'b0, 4'd0, 16'h0);
    chk("t3_done_code", 32'({done, err_code, count}), {24'd0, 1'b1, 2'b10, 5'd1});

    // illegal op first, later range error keeps the first code
    do_start();
    chk("t4_err_cleared", 32'({err, err_code}), 0);
    send("op_e", 4'hE, 4'd1, 4'd1, 4'd1, 12'd0, 1'b0, 1'b0, 4'd0, 16'h0);
    chk("t4_code01", 32'({err, err_code}), 32'b101);
    send("range_after", 4'h1, 4'd0, 4'd0, 4'd0, 12'h010, 1'b1, 1'b0, 4'd0, 16'h0);
    chk("t4_code_kept", 32'({done, err, err_code, count}), {24'd0, 1'b1, 1'b1, 2'b01, 5'd0});

    // shift and lui immediate boundaries
    do_start();
    send("sll15", 4'hB, 4'd1, 4'd2, 4'd0, 12'h00F, 1'b0, 1'b1, 4'd0, 16'hB12F);
    send("lui255", 4'h7, 4'd9, 4'd3, 4'd0, 12'h0FF, 1'b0, 1'b1, 4'd1, 16'h73FF);
    send("lui256", 4'h7, 4'd0, 4'd3, 4'd0, 12'h100, 1'b0, 1'b0, 4'd0, 16'h0);
    send("sll16", 4'hB, 4'd1, 4'd2, 4'd0, 12'h010, 1'b1, 1'b0, 4'd0, 16'h0);
    chk("t5_shift_state", 32'({done, err, err_code, count}), {24'd0, 1'b1, 1'b1, 2'b10, 5'd2});

    // fill the 4-word encoder; the 16-word one keeps accepting
    do_start();
    for (int i = 0; i < 4; i++) begin
      send("fill", 4'h0, 4'(i), 4'(i), 4'(i), 12'd0, 1'b0, 1'b1, 4'(i),
           {4'h0, 4'(i), 4'(i), 4'(i)});
      chk("fill_small_we_addr", 32'({imem_we2, imem_addr2}), {29'd0, 1'b1, 2'(i)});
    end
    @(negedge clk);
    chk("full_small", 32'({full2, done2, req_ready2, busy2, count2}), {25'd0, 4'b1100, 3'd4});
    chk("full_big", 32'({full, done, req_ready}), 32'b001);
    send("fifth", 4'h0, 4'd7, 4'd7, 4'd7, 12'd0, 1'b1, 1'b1, 4'd4, 16'h0777);
    chk("fifth_small_ignored", 32'({imem_we2, count2}), {28'd0, 1'b0, 3'd4});

    // reset during WRITE
    do_start();
    send("pre_rst", 4'h1, 4'd3, 4'd3, 4'd0, 12'd1, 1'b0, 1'b1, 4'd0, 16'h1331);
    #1 rst = 1'b1;
    #1 chk_all_zero("mid_rst");
    @(negedge clk); rst = 1'b0;
    do_start();
    send("reload", 4'h1, 4'd4, 4'd5, 4'd0, 12'hFFF, 1'b1, 1'b1, 4'd0, 16'h145F);
    @(negedge clk);
    chk("t6_done_count", 32'({done, count}), {26'd0, 1'b1, 5'd1});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
